// File: rtl/pdm_mic_decimator.sv
// PDM microphone receiver: generates the mic clock, samples the 1-bit stream on each
// mic clock rising edge and boxcar-decimates it to signed PCM on a valid/ready stream.
module pdm_mic_decimator #(
    parameter int CLK_DIV    = 32,
    parameter int DECIMATION = 512,
    parameter int OUT_WIDTH  = 8,
    parameter int FRAME_LEN  = 512
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 mic_data_in,
    output logic                 mic_clk_out,
    output logic                 pdm_tick_out,
    output logic [OUT_WIDTH-1:0] sample_data_out,
    output logic                 sample_valid_out,
    output logic                 sample_last_out,
    input  logic                 sample_ready_in,
    output logic                 overrun_out
);

    // Stream handshake: a sample transfers on every clk_in edge where
    // sample_valid_out & sample_ready_in; data/last hold while valid & !ready,
    // and valid only falls after a transfer.

    localparam int DW    = $clog2(CLK_DIV);
    localparam int BW    = $clog2(DECIMATION);
    localparam int TW    = BW + 1;
    localparam int CW    = TW + 1;
    localparam int FW    = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam int SHIFT = BW - OUT_WIDTH;

    localparam logic [DW-1:0]        DIV_LAST   = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0]        DIV_HALF   = DW'(CLK_DIV / 2);
    localparam logic [BW-1:0]        BIT_LAST   = BW'(DECIMATION - 1);
    localparam logic [FW-1:0]        FRAME_LAST = FW'(FRAME_LEN - 1);
    localparam logic signed [CW-1:0] HALF_SCALE = CW'(DECIMATION / 2);
    localparam logic signed [CW-1:0] CMP_MAX    = CW'((2 ** (OUT_WIDTH - 1)) - 1);
    localparam logic signed [CW-1:0] CMP_MIN    = CW'(-(2 ** (OUT_WIDTH - 1)));
    localparam logic [OUT_WIDTH-1:0] PCM_MAX    = {1'b0, {(OUT_WIDTH - 1){1'b1}}};
    localparam logic [OUT_WIDTH-1:0] PCM_MIN    = {1'b1, {(OUT_WIDTH - 1){1'b0}}};

    logic [DW-1:0]        r_div_cnt;
    logic                 r_mic_clk;
    logic                 r_mic_clk_q;
    logic [BW-1:0]        r_bit_cnt;
    logic [TW-1:0]        r_tally;
    logic [FW-1:0]        r_frame_cnt;
    logic [OUT_WIDTH-1:0] r_data;
    logic                 r_valid;
    logic                 r_last;
    logic                 r_overrun;

    logic                 w_tick;
    logic                 w_window_done;
    logic                 w_slot_free;
    logic [TW-1:0]        w_total;
    logic signed [CW-1:0] w_centered;
    logic signed [CW-1:0] w_shifted;
    logic [OUT_WIDTH-1:0] w_pcm;

    assign w_tick        = r_mic_clk & ~r_mic_clk_q;
    assign w_window_done = w_tick && (r_bit_cnt == BIT_LAST);
    assign w_slot_free   = !r_valid || sample_ready_in;
    assign w_total       = r_tally + TW'(mic_data_in);
    assign w_centered    = $signed({1'b0, w_total}) - HALF_SCALE;
    assign w_shifted     = w_centered >>> SHIFT;

    // Only an all-ones window exceeds the positive range; the low clamp is defensive.
    always_comb begin
        w_pcm = w_shifted[OUT_WIDTH-1:0];
        if (w_shifted > CMP_MAX) begin
            w_pcm = PCM_MAX;
        end else if (w_shifted < CMP_MIN) begin
            w_pcm = PCM_MIN;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_div_cnt   <= '0;
            r_mic_clk   <= 1'b0;
            r_mic_clk_q <= 1'b0;
            r_bit_cnt   <= '0;
            r_tally     <= '0;
            r_frame_cnt <= '0;
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_last      <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_div_cnt   <= (r_div_cnt == DIV_LAST) ? '0 : r_div_cnt + 1'b1;
            r_mic_clk   <= (r_div_cnt < DIV_HALF);
            r_mic_clk_q <= r_mic_clk;

            if (w_tick) begin
                if (w_window_done) begin
                    r_tally   <= '0;
                    r_bit_cnt <= '0;
                end else begin
                    r_tally   <= w_total;
                    r_bit_cnt <= r_bit_cnt + 1'b1;
                end
            end

            // The decimator never stalls: a completed window with no free slot is lost.
            if (w_window_done) begin
                if (w_slot_free) begin
                    r_data      <= w_pcm;
                    r_valid     <= 1'b1;
                    r_last      <= (r_frame_cnt == FRAME_LAST);
                    r_frame_cnt <= (r_frame_cnt == FRAME_LAST) ? '0 : r_frame_cnt + 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_valid && sample_ready_in) begin
                r_valid <= 1'b0;
                r_last  <= 1'b0;
            end
        end
    end

    assign mic_clk_out      = r_mic_clk;
    assign pdm_tick_out     = w_tick;
    assign sample_data_out  = r_data;
    assign sample_valid_out = r_valid;
    assign sample_last_out  = r_last;
    assign overrun_out      = r_overrun;

endmodule

// File: tb/tb_pdm_mic_decimator.sv
// Bench for pdm_mic_decimator: a cycle-level behavioural model of the mic clock, window
// sums and single-slot output, directed phases with literal pins, and a random soak.
module tb_pdm_mic_decimator;

    localparam int CLK_DIV  = 4;
    localparam int DEC      = 16;
    localparam int OW       = 4;
    localparam int FL       = 3;
    localparam int W        = OW + 1;
    localparam int LOG2_DEC = $clog2(DEC);

    logic          clk_in = 1'b0;
    logic          rst_in = 1'b1;
    logic          mic_data_in = 1'b0;
    logic          sample_ready_in = 1'b0;
    logic          mic_clk_out;
    logic          pdm_tick_out;
    logic [OW-1:0] sample_data_out;
    logic          sample_valid_out;
    logic          sample_last_out;
    logic          overrun_out;

    logic          d_rst = 1'b1;
    logic          d_mic_clk;
    logic          d_tick;
    logic [7:0]    d_data;
    logic          d_valid;
    logic          d_last;
    logic          d_ovr;

    always #5 clk_in = ~clk_in;

    pdm_mic_decimator #(
        .CLK_DIV(CLK_DIV), .DECIMATION(DEC), .OUT_WIDTH(OW), .FRAME_LEN(FL)
    ) dut (
        .clk_in(clk_in), .rst_in(rst_in), .mic_data_in(mic_data_in),
        .mic_clk_out(mic_clk_out), .pdm_tick_out(pdm_tick_out),
        .sample_data_out(sample_data_out), .sample_valid_out(sample_valid_out),
        .sample_last_out(sample_last_out), .sample_ready_in(sample_ready_in),
        .overrun_out(overrun_out)
    );

    pdm_mic_decimator dut_default (
        .clk_in(clk_in), .rst_in(d_rst), .mic_data_in(1'b1),
        .mic_clk_out(d_mic_clk), .pdm_tick_out(d_tick),
        .sample_data_out(d_data), .sample_valid_out(d_valid),
        .sample_last_out(d_last), .sample_ready_in(1'b1),
        .overrun_out(d_ovr)
    );

    int compared = 0;
    int mismatched = 0;

    // Model state: n = clock edges since reset release, cnt/sum = current window.
    int n, cnt, sum, frame, win_idx, m_data;
    logic m_valid, m_last, m_ovr;
    logic [W-1:0] exp_q[$];

    int bit_mode, rdy_mode, acc_cnt, last_cnt, last_acc_data, tot_steps;
    logic last_acc_last;

    int d_n, d_first_data;
    logic d_live, d_valid_prev, d_clk_prev;
    int d_rise[$];
    int d_clk_rise[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, $signed(act), $signed(exp), $time);
        end
    endtask

    function automatic int pcm_of(input int total);
        int c, p;
        c = total - DEC / 2;
        p = c >>> (LOG2_DEC - OW);
        if (p > 2 ** (OW - 1) - 1) p = 2 ** (OW - 1) - 1;
        if (p < -(2 ** (OW - 1))) p = -(2 ** (OW - 1));
        return p;
    endfunction

    task automatic model_reset();
        n = 0; cnt = 0; sum = 0; frame = 0; win_idx = 0; m_data = 0;
        m_valid = 1'b0; m_last = 1'b0; m_ovr = 1'b0;
        exp_q.delete();
    endtask

    task automatic step(input logic rst);
        logic exp_clk, tick, done, b, r;
        int total, pcm;
        logic [W-1:0] e;
        @(negedge clk_in);
        tot_steps++;
        exp_clk = (n >= 1) && (((n - 1) % CLK_DIV) < CLK_DIV / 2);
        tick    = (n >= 1) && ((n % CLK_DIV) == 1);
        done    = tick && (cnt == DEC - 1);
        check("mic_clk", 32'(mic_clk_out), 32'(exp_clk));
        check("tick", 32'(pdm_tick_out), 32'(tick));
        check("valid", 32'(sample_valid_out), 32'(m_valid));
        check("data", 32'($signed(sample_data_out)), m_data);
        check("last", 32'(sample_last_out), 32'(m_last));
        check("overrun", 32'(overrun_out), 32'(m_ovr));

        if (d_live) begin
            if (d_valid && !d_valid_prev) begin
                if (d_rise.size() == 0) d_first_data = 32'($signed(d_data));
                d_rise.push_back(d_n);
            end
            if (d_mic_clk && !d_clk_prev) d_clk_rise.push_back(d_n);
            d_valid_prev = d_valid;
            d_clk_prev   = d_mic_clk;
        end

        case (bit_mode)
            0: b = 1'b1;
            1: b = 1'b0;
            2: b = (cnt % 2 == 0);
            3: b = (cnt < 12);
            4: b = 1'($urandom_range(0, 1));
            default: b = (win_idx == 0) ? 1'b1 : (win_idx == 1) ? 1'b0 : (cnt % 2 == 0);
        endcase
        case (rdy_mode)
            0: r = 1'b1;
            1: r = 1'b0;
            2: r = 1'($urandom_range(0, 1));
            default: r = done;
        endcase
        mic_data_in = b;
        sample_ready_in = r;
        rst_in = rst;
        if (!rst && !d_live) begin
            d_rst = 1'b0; d_live = 1'b1; d_n = 0;
            d_valid_prev = 1'b0; d_clk_prev = 1'b0;
        end
        if (d_live) d_n++;

        if (rst) begin
            model_reset();
        end else begin
            if (m_valid && r) begin
                acc_cnt++;
                last_acc_data = 32'($signed(sample_data_out));
                last_acc_last = sample_last_out;
                if (sample_last_out) last_cnt++;
                if (exp_q.size() == 0) begin
                    check("acc_queue_nonempty", 32'(0), 32'(1));
                end else begin
                    e = exp_q.pop_front();
                    check("acc_data", 32'($signed(sample_data_out)), 32'($signed(e[OW-1:0])));
                    check("acc_last", 32'(sample_last_out), 32'(e[OW]));
                end
            end
            if (done) begin
                total = sum + int'(b);
                sum = 0; cnt = 0; win_idx++;
                if (!m_valid || r) begin
                    pcm = pcm_of(total);
                    m_data = pcm; m_valid = 1'b1; m_last = (frame == FL - 1);
                    frame = (frame + 1) % FL;
                    e = {m_last, pcm[OW-1:0]};
                    exp_q.push_back(e);
                end else begin
                    m_ovr = 1'b1;
                end
            end else begin
                if (tick) begin
                    sum += int'(b); cnt++;
                end
                if (m_valid && r) begin
                    m_valid = 1'b0; m_last = 1'b0;
                end
            end
            n++;
        end
    endtask

    task automatic run(input int k);
        for (int i = 0; i < k; i++) step(1'b0);
    endtask

    task automatic do_reset();
        repeat (2) step(1'b1);
        acc_cnt = 0; last_cnt = 0; last_acc_data = 99; last_acc_last = 1'b0;
    endtask

    initial begin
        model_reset();
        tot_steps = 0; d_live = 1'b0; d_n = 0; d_first_data = 0;
        bit_mode = 0; rdy_mode = 0;

        // Constant ones: 9 samples, every one saturates to +7, last on 3/6/9.
        do_reset();
        run(600);
        check("ones_value", 32'(last_acc_data), 32'(7));
        check("ones_count", 32'(acc_cnt), 32'(9));
        check("ones_last_count", 32'(last_cnt), 32'(3));
        check("ones_last_flag", 32'(last_acc_last), 32'(1));

        bit_mode = 1; do_reset(); run(200);
        check("zeros_value", 32'(last_acc_data), 32'(-8));
        bit_mode = 2; do_reset(); run(200);
        check("alt_value", 32'(last_acc_data), 32'(0));
        bit_mode = 3; do_reset(); run(200);
        check("twelve_value", 32'(last_acc_data), 32'(4));

        // Backpressure across two windows, then release.
        bit_mode = 5; rdy_mode = 1; do_reset(); run(70);
        check("bp_valid", 32'(sample_valid_out), 32'(1));
        check("bp_data1", 32'($signed(sample_data_out)), 32'(7));
        check("bp_ovr_before", 32'(overrun_out), 32'(0));
        run(60);
        check("bp_ovr_after", 32'(overrun_out), 32'(1));
        check("bp_data_held", 32'($signed(sample_data_out)), 32'(7));
        rdy_mode = 0; run(1);
        check("bp_first_accepted", 32'(last_acc_data), 32'(7));
        run(70);
        check("bp_third_value", 32'(last_acc_data), 32'(0));
        check("bp_acc_count", 32'(acc_cnt), 32'(2));
        check("bp_ovr_sticky", 32'(overrun_out), 32'(1));

        // Ready only in the completing-tick cycle: swap with no overrun.
        bit_mode = 0; rdy_mode = 3; do_reset(); run(130);
        check("swap_ovr", 32'(overrun_out), 32'(0));
        check("swap_valid", 32'(sample_valid_out), 32'(1));
        check("swap_acc", 32'(acc_cnt), 32'(1));

        // Reset at bit 9 of the second window while a sample is held.
        bit_mode = 0; rdy_mode = 1; do_reset(); run(102);
        check("pre_rst_valid", 32'(sample_valid_out), 32'(1));
        step(1'b1); model_reset();
        bit_mode = 1; rdy_mode = 0; run(1);
        check("rst_mic_clk", 32'(mic_clk_out), 32'(0));
        check("rst_valid", 32'(sample_valid_out), 32'(0));
        check("rst_data", 32'(sample_data_out), 32'(0));
        check("rst_ovr", 32'(overrun_out), 32'(0));
        acc_cnt = 0;
        run(70);
        check("post_rst_value", 32'(last_acc_data), 32'(-8));
        check("post_rst_count", 32'(acc_cnt), 32'(1));

        // Random soak, long enough for two samples from the default-parameter instance.
        bit_mode = 4; rdy_mode = 2; do_reset();
        while (tot_steps < 33200) step(1'b0);

        if (d_rise.size() >= 2 && d_clk_rise.size() >= 2) begin
            check("def_first_sample", 32'(d_rise[0]), 32'(16354));
            check("def_sample_period", 32'(d_rise[1] - d_rise[0]), 32'(16384));
            check("def_value", 32'(d_first_data), 32'(127));
            check("def_mic_clk_period", 32'(d_clk_rise[1] - d_clk_rise[0]), 32'(32));
        end else begin
            check("def_events_seen", 32'(0), 32'(1));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
